// File: rtl/jtdd_dwnld.sv
// jtdd_dwnld: turns the ioctl ROM byte stream into buffered 16-bit masked SDRAM writes and priority-PROM strobes.
// Define JTDD_DWNLD_SUM_EN to add the dwnld_sum byte checksum output.
module jtdd_dwnld #(
    parameter logic [21:0] SCR_START  = 22'h6_0000,
    parameter int          SCR_AW     = 18,
    parameter logic [21:0] SCR_ADDR   = 22'h4_0000,
    parameter logic [21:0] OBJ_START  = 22'hA_0000,
    parameter int          OBJ_AW     = 19,
    parameter logic [21:0] OBJ_ADDR   = 22'h8_0000,
    parameter logic [21:0] PROM_START = 22'h1A_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        prog_ack,
    output logic        prom_prio_we,
    output logic        dwnld_busy,
`ifdef JTDD_DWNLD_SUM_EN
    output logic [15:0] dwnld_sum,
`endif
    output logic        overflow
);
    localparam logic [21:0] SCR_H = 22'd1 << (SCR_AW - 1);
    localparam logic [21:0] OBJ_H = 22'd1 << (OBJ_AW - 1);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t      state, state_n;
    logic        accept, n_sdram, n_prom;
    logic [21:0] scr_o, obj_o, n_word;
    logic [1:0]  n_mask;
    logic        t_valid, t_prom;
    logic [21:0] t_word;
    logic [7:0]  t_data;
    logic [1:0]  t_mask;
    logic [21:0] mem_word [2];
    logic [7:0]  mem_data [2];
    logic [1:0]  mem_mask [2];
    logic        wr_ptr, rd_ptr, push_ok, pop;
    logic [1:0]  count;

    always_comb begin
        accept  = ioctl_wr && downloading;
        scr_o   = ioctl_addr - SCR_START;
        obj_o   = ioctl_addr - OBJ_START;
        n_sdram = accept && ioctl_addr < PROM_START;
        n_prom  = accept && ioctl_addr >= PROM_START && ioctl_addr < PROM_START + 22'd256;
        n_word  = ioctl_addr < SCR_START ? ioctl_addr >> 1 :
                  ioctl_addr < OBJ_START ? SCR_ADDR + (scr_o < SCR_H ? scr_o : scr_o - SCR_H) :
                  ioctl_addr < PROM_START ? OBJ_ADDR + (obj_o < OBJ_H ? obj_o : obj_o - OBJ_H) :
                  ioctl_addr;
        n_mask  = ioctl_addr < SCR_START ? (ioctl_addr[0] ? 2'b01 : 2'b10) :
                  ioctl_addr < OBJ_START ? (scr_o < SCR_H ? 2'b10 : 2'b01) :
                  (obj_o < OBJ_H ? 2'b10 : 2'b01);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid <= 1'b0;
            t_prom  <= 1'b0;
            t_word  <= '0;
            t_data  <= '0;
            t_mask  <= 2'b11;
        end else begin
            t_valid <= n_sdram;
            t_prom  <= n_prom;
            t_word  <= n_word;
            t_data  <= ioctl_data;
            t_mask  <= n_mask;
        end
    end

    // a push into a full FIFO is still taken when the head is popped in the same cycle
    assign pop     = prog_we && prog_ack;
    assign push_ok = t_valid && (count != 2'd2 || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_word[wr_ptr] <= t_word;
            mem_data[wr_ptr] <= t_data;
            mem_mask[wr_ptr] <= t_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
        end else begin
            wr_ptr   <= wr_ptr ^ push_ok;
            rd_ptr   <= rd_ptr ^ pop;
            count    <= count + 2'(push_ok) - 2'(pop);
            overflow <= overflow | (t_valid && !push_ok);
            state    <= state_n;
        end
    end

    // returning to IDLE after each ack gives the one-cycle gap between writes
    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = (count != 2'd0 || t_valid) ? ISSUE : IDLE;
        else if (prog_ack) state_n = IDLE;
    end

    always_comb begin
        prog_we      = state == ISSUE;
        prom_prio_we = t_prom;
        prog_addr    = t_prom ? {14'd0, t_word[7:0]} : prog_we ? mem_word[rd_ptr] : 22'd0;
        prog_data    = t_prom ? t_data : prog_we ? mem_data[rd_ptr] : 8'd0;
        prog_mask    = prog_we ? mem_mask[rd_ptr] : 2'b11;
        dwnld_busy   = downloading || count != 2'd0 || prog_we || t_valid || t_prom;
    end

`ifdef JTDD_DWNLD_SUM_EN
    logic dl_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_d      <= 1'b0;
            dwnld_sum <= '0;
        end else begin
            dl_d      <= downloading;
            dwnld_sum <= (downloading && !dl_d) ? (accept ? 16'(ioctl_data) : 16'd0) :
                         accept ? dwnld_sum + 16'(ioctl_data) : dwnld_sum;
        end
    end
`endif
endmodule

// File: tb/tb_jtdd_dwnld.sv
// tb_jtdd_dwnld: directed self-checking bench for jtdd_dwnld.
module tb_jtdd_dwnld;
    logic        clk = 0, rst_n = 0, downloading = 0, ioctl_wr = 0, prog_ack = 0;
    logic [21:0] ioctl_addr = 0;
    logic [7:0]  ioctl_data = 0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we, prom_prio_we, dwnld_busy, overflow;
`ifdef JTDD_DWNLD_SUM_EN
    logic [15:0] dwnld_sum;
`endif
    int checks = 0, failures = 0;

    jtdd_dwnld dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack), .prom_prio_we(prom_prio_we),
        .dwnld_busy(dwnld_busy),
`ifdef JTDD_DWNLD_SUM_EN
        .dwnld_sum(dwnld_sum),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1;
        tick();
        ioctl_wr   = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if ({prog_we, prog_mask, prog_addr, prog_data, prom_prio_we, dwnld_busy, overflow} !== {1'b0, 2'b11, 22'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset: we=%b mask=%b addr=%h data=%h prom=%b busy=%b ovf=%b, want 0/11/0/0/0/0/0",
                     prog_we, prog_mask, prog_addr, prog_data, prom_prio_we, dwnld_busy, overflow);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_linear();
        downloading = 1;
        strobe(22'h0_0003, 8'h5A);
        checks++;
        if (prog_we !== 1'b0) begin failures++; $display("FAIL lin_n1_we: got %b want 0", prog_we); end
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 22'h0_0001, 2'b01, 8'h5A}) begin
            failures++;
            $display("FAIL lin_n2: we=%b addr=%h mask=%b data=%h want 1/000001/01/5a", prog_we, prog_addr, prog_mask, prog_data);
        end
        tick();
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 22'h0_0001, 2'b01, 8'h5A}) begin
            failures++;
            $display("FAIL lin_hold: we=%b addr=%h mask=%b data=%h want 1/000001/01/5a", prog_we, prog_addr, prog_mask, prog_data);
        end
        tick();
        prog_ack = 1;
        tick();
        prog_ack = 0;
        checks++;
        if ({prog_we, prog_mask} !== {1'b0, 2'b11}) begin
            failures++;
            $display("FAIL lin_after_ack: we=%b mask=%b want 0/11", prog_we, prog_mask);
        end
        // even linear address selects the high lane inhibit
        strobe(22'h0_0010, 8'h33);
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_mask} !== {1'b1, 22'h0_0008, 2'b10}) begin
            failures++;
            $display("FAIL lin_even: we=%b addr=%h mask=%b want 1/000008/10", prog_we, prog_addr, prog_mask);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
    endtask

    task automatic test_regions();
        strobe(22'h6_0001, 8'h11);
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_mask} !== {1'b1, 22'h4_0001, 2'b10}) begin
            failures++;
            $display("FAIL scr_low: we=%b addr=%h mask=%b want 1/040001/10", prog_we, prog_addr, prog_mask);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
        strobe(22'h8_0001, 8'h22);
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_mask} !== {1'b1, 22'h4_0001, 2'b01}) begin
            failures++;
            $display("FAIL scr_high: we=%b addr=%h mask=%b want 1/040001/01", prog_we, prog_addr, prog_mask);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
        strobe(22'hE_0002, 8'h44);
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_mask} !== {1'b1, 22'h8_0002, 2'b01}) begin
            failures++;
            $display("FAIL obj_high: we=%b addr=%h mask=%b want 1/080002/01", prog_we, prog_addr, prog_mask);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
        strobe(22'hA_0005, 8'h45);
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_mask} !== {1'b1, 22'h8_0005, 2'b10}) begin
            failures++;
            $display("FAIL obj_low: we=%b addr=%h mask=%b want 1/080005/10", prog_we, prog_addr, prog_mask);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
    endtask

    task automatic test_prom();
        strobe(22'h1A_003C, 8'h07);
        checks++;
        if ({prom_prio_we, prog_addr[7:0], prog_data, prog_we} !== {1'b1, 8'h3C, 8'h07, 1'b0}) begin
            failures++;
            $display("FAIL prom: prom=%b addr=%h data=%h we=%b want 1/3c/07/0", prom_prio_we, prog_addr[7:0], prog_data, prog_we);
        end
        tick();
        tick();
        checks++;
        if ({prom_prio_we, prog_we} !== 2'b00) begin
            failures++;
            $display("FAIL prom_after: prom=%b we=%b want 0/0", prom_prio_we, prog_we);
        end
        strobe(22'h1A_0100, 8'h99);
        tick();
        checks++;
        if ({prom_prio_we, prog_we} !== 2'b00) begin
            failures++;
            $display("FAIL discard: prom=%b we=%b want 0/0", prom_prio_we, prog_we);
        end
        downloading = 0;
        strobe(22'h0_0004, 8'h01);
        tick();
        checks++;
        if ({prog_we, dwnld_busy} !== 2'b00) begin
            failures++;
            $display("FAIL idle_wr: we=%b busy=%b want 0/0", prog_we, dwnld_busy);
        end
        downloading = 1;
    endtask

    task automatic test_back_to_back();
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre: got %b want 0", overflow); end
        ioctl_wr = 1;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 22'h100 + 22'(2 * i);
            ioctl_data = 8'hA0 + 8'(i);
            tick();
        end
        ioctl_wr = 0;
        repeat (20) tick();
        checks++;
        if ({overflow, prog_we, prog_addr, prog_data} !== {1'b1, 1'b1, 22'h80, 8'hA0}) begin
            failures++;
            $display("FAIL bp_first: ovf=%b we=%b addr=%h data=%h want 1/1/000080/a0", overflow, prog_we, prog_addr, prog_data);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
        checks++;
        if (prog_we !== 1'b0) begin failures++; $display("FAIL bp_gap: we=%b want 0", prog_we); end
        tick();
        checks++;
        if ({prog_we, prog_addr, prog_data} !== {1'b1, 22'h81, 8'hA1}) begin
            failures++;
            $display("FAIL bp_second: we=%b addr=%h data=%h want 1/000081/a1", prog_we, prog_addr, prog_data);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
        repeat (3) tick();
        checks++;
        if ({prog_we, overflow} !== 2'b01) begin
            failures++;
            $display("FAIL bp_done: we=%b ovf=%b want 0/1", prog_we, overflow);
        end
    endtask

    task automatic test_drain();
        ioctl_wr   = 1;
        ioctl_addr = 22'h200;
        ioctl_data = 8'hB0;
        tick();
        ioctl_addr = 22'h202;
        ioctl_data = 8'hB1;
        tick();
        ioctl_wr    = 0;
        downloading = 0;
        checks++;
        if ({prog_we, dwnld_busy, prog_addr} !== {1'b1, 1'b1, 22'h100}) begin
            failures++;
            $display("FAIL drain_first: we=%b busy=%b addr=%h want 1/1/000100", prog_we, dwnld_busy, prog_addr);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
        checks++;
        if ({prog_we, dwnld_busy} !== 2'b01) begin
            failures++;
            $display("FAIL drain_gap: we=%b busy=%b want 0/1", prog_we, dwnld_busy);
        end
        tick();
        checks++;
        if ({prog_we, dwnld_busy, prog_addr} !== {1'b1, 1'b1, 22'h101}) begin
            failures++;
            $display("FAIL drain_second: we=%b busy=%b addr=%h want 1/1/000101", prog_we, dwnld_busy, prog_addr);
        end
        prog_ack = 1;
        tick();
        prog_ack = 0;
        checks++;
        if ({prog_we, dwnld_busy} !== 2'b00) begin
            failures++;
            $display("FAIL drain_end: we=%b busy=%b want 0/0", prog_we, dwnld_busy);
        end
    endtask

    task automatic test_reset_mid();
        downloading = 1;
        strobe(22'h0_0006, 8'hC3);
        tick();
        checks++;
        if (prog_we !== 1'b1) begin failures++; $display("FAIL rst_pre: we=%b want 1", prog_we); end
        rst_n = 0;
        #1;
        checks++;
        if ({prog_we, prog_mask, overflow} !== {1'b0, 2'b11, 1'b0}) begin
            failures++;
            $display("FAIL rst_async: we=%b mask=%b ovf=%b want 0/11/0", prog_we, prog_mask, overflow);
        end
        tick();
        rst_n = 1;
        repeat (5) tick();
        checks++;
        if ({prog_we, prog_mask} !== {1'b0, 2'b11}) begin
            failures++;
            $display("FAIL rst_after: we=%b mask=%b want 0/11", prog_we, prog_mask);
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_regions();
        test_prom();
        test_back_to_back();
        test_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtdd_dwnld.md
Name: jtdd_dwnld

Overview:
- Upstream stage of the game-level ROM interface; replaces the constant prog_addr/dwnld_busy ties.
- Converts the ioctl byte stream (JTDD.rom layout) into 16-bit masked SDRAM programming writes, remapping graphics regions into the reallocated SCR/OBJ areas.
- Diverts the priority-PROM bytes to a one-cycle prom_prio_we strobe.
- Buffers translated writes in a 2-entry FIFO so ioctl bursts survive SDRAM write latency.

Parameters:
- SCR_START, 22'h6_0000, first ioctl byte address of scroll graphics in the file.
- SCR_AW, 18, log2 of scroll region size in bytes.
- SCR_ADDR, 22'h4_0000, word offset of scroll data in SDRAM.
- OBJ_START, 22'hA_0000, first ioctl byte address of object graphics.
- OBJ_AW, 19, log2 of object region size in bytes.
- OBJ_ADDR, 22'h8_0000, word offset of object data in SDRAM.
- PROM_START, 22'h1A_0000, first ioctl byte address of the 256-byte priority PROM.

Ports:
- clk  in  1  system clock, 48 MHz.
- rst_n  in  1  asynchronous active-low reset.
- downloading  in  1  download window active.
- ioctl_addr  in  22  byte address within the ROM file.
- ioctl_data  in  8  byte value.
- ioctl_wr  in  1  one-cycle byte strobe.
- prog_addr  out  22  SDRAM word address; bits [7:0] carry the PROM address during prom_prio_we.
- prog_data  out  8  byte to write, duplicated on both SDRAM byte lanes by the top level.
- prog_mask  out  2  per-byte write inhibit; 1 means the byte is not written.
- prog_we  out  1  SDRAM write request, held until acknowledged.
- prog_ack  in  1  one-cycle acknowledge from the SDRAM controller.
- prom_prio_we  out  1  one-cycle priority-PROM write strobe.
- dwnld_busy  out  1  download or write drain in progress.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, except prog_mask = 2'b11. FIFO is emptied.
- Translation, registered one cycle after ioctl_wr. Let a = ioctl_addr.
  - a < SCR_START, linear region: word = a>>1; mask = a[0] ? 2'b01 : 2'b10.
  - SCR_START <= a < OBJ_START, scroll region: o = a - SCR_START, h = 2^(SCR_AW-1).
    - Lower half (o < h): word = SCR_ADDR + o, mask 2'b10.
    - Upper half: word = SCR_ADDR + (o - h), mask 2'b01.
  - OBJ_START <= a < PROM_START, object region: same rule with OBJ_AW and OBJ_ADDR.
  - PROM_START <= a < PROM_START+256: bypasses the FIFO. In the translate cycle, prom_prio_we=1 for one clk, prog_addr[7:0]=a[7:0], prog_data=byte. prog_we stays low that cycle and prog_we/FIFO state are unaffected.
  - a >= PROM_START+256: discarded silently.
  - Word arithmetic is 22-bit unsigned; carries beyond bit 21 are dropped.
- ioctl_wr while downloading=0 is ignored.
- FIFO: 2 entries of {word, data, mask}.
  - Push on a translated SDRAM write; pop when prog_we && prog_ack.
  - Simultaneous push and pop when full is allowed: the pop frees the slot.
  - Push when full and no pop: the byte is dropped and overflow is set. overflow stays set until reset.
- Write FSM states:
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE: drive the head onto prog_addr/prog_data/prog_mask and assert prog_we. These outputs are stable while prog_we=1.
  - On prog_ack: pop. If more entries remain, present the next one the following cycle (prog_we low for exactly one cycle between writes). Otherwise go to IDLE, with prog_we=0 and prog_mask=2'b11.
  - prog_ack while prog_we=0 is ignored.
- Latency: ioctl_wr at cycle n with an empty FIFO -> prog_we=1 at cycle n+2.
- dwnld_busy = downloading | FIFO non-empty | prog_we | translate stage valid. It falls one cycle after the last ack once downloading=0.
- If downloading falls mid-burst, buffered entries still drain.
- Reset mid-operation: pending entries are lost and prog_we drops immediately.

Optional Feature:
- Macro: JTDD_DWNLD_SUM_EN.
- With the macro: extra output dwnld_sum [15:0], the modulo-2^16 sum of every accepted byte (including PROM and discarded-range bytes). It clears on the rising edge of downloading and on reset, and is used for ROM integrity checks from the OSD.
- Without the macro: port and adder are absent; behaviour is otherwise identical.

Test Plan:
- Linear write: a=22'h0_0003, data 8'h5A, ack 3 cycles after prog_we -> prog_addr=22'h0_0001, mask=2'b01, prog_data=8'h5A. prog_we rises at n+2 and falls the cycle after ack.
- Scroll split: a=SCR_START+1 -> word 22'h4_0001, mask 2'b10. a=SCR_START+22'h2_0001 -> word 22'h4_0001, mask 2'b01.
- PROM: a=PROM_START+8'h3C, data 8'h07 -> single-cycle prom_prio_we with prog_addr[7:0]=8'h3C, prog_data=8'h07; no prog_we.
- Backpressure: 4 strobes on consecutive cycles, prog_ack withheld 20 cycles -> 2 entries kept, overflow=1, only those 2 writes issued after acks.
- Drain: downloading falls with 2 entries pending -> dwnld_busy stays 1 until the second ack, then 0 the next cycle.
- Reset: assert rst_n=0 while prog_we=1 -> prog_we=0, prog_mask=2'b11, overflow=0 immediately; no write issued after release without a new strobe.
